handshake_packer: RTL and testbench

- Downstream neighbour of the 8-bit valid/ready pipeline register stage.
- Consumes its byte stream (valid/ready/data plus a last marker) and packs RATIO consecutive beats into one wide word, little-endian.
- Presents the word on a registered valid/ready output with a per-beat keep mask, so the wide consumer (bus write port, FIFO) sees whole or flushed-partial words.
- Sustains one input beat per cycle while the output is not back-pressured.

---
 rtl/handshake_packer_pkg.sv | 12 +
 rtl/handshake_packer_if.sv | 33 +++
 rtl/handshake_packer_hs_out_reg.sv | 57 +++++
 rtl/handshake_packer.sv | 94 +++++++++
 tb/tb_handshake_packer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/handshake_packer_pkg.sv
// -----------------------------------------------------------------------------
// handshake_packer_pkg
// Shared defaults for the byte-to-word packer slice.
//   DEF_DATA_W : default width of one input beat
//   DEF_RATIO  : default number of beats per packed output word
// -----------------------------------------------------------------------------
package handshake_packer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_RATIO  = 4;

endpackage

// File: rtl/handshake_packer_if.sv
// -----------------------------------------------------------------------------
// handshake_packer_if
// Narrow valid/ready input stream plus the wide valid/ready/keep/last output
// stream of the packer.
//   master : drives in_valid/in_data/in_last and out_ready (source and sink side)
//   slave  : the packer; drives in_ready and the out_* word signals
// -----------------------------------------------------------------------------
interface handshake_packer_if #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
) ();

    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_last;
    logic                     in_ready;
    logic                     out_valid;
    logic [DATA_W*RATIO-1:0]  out_data;
    logic [RATIO-1:0]         out_keep;
    logic                     out_last;
    logic                     out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

endinterface

// File: rtl/handshake_packer_hs_out_reg.sv
// -----------------------------------------------------------------------------
// hs_out_reg
// Single-entry valid/ready output register holding a packed word, its keep mask
// and its last flag. A load replaces the entry and keeps it valid, so a word
// can be drained and refilled at the same edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture i_data/i_keep/i_last and assert o_valid
//   i_ready    : downstream ready; drains the entry when no load is present
//   o_valid, o_data, o_keep, o_last : registered output word
// -----------------------------------------------------------------------------
module hs_out_reg #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [DATA_W*RATIO-1:0] i_data,
    input  logic [RATIO-1:0]        i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [DATA_W*RATIO-1:0] o_data,
    output logic [RATIO-1:0]        o_keep,
    output logic                    o_last
);

    logic                    r_valid;
    logic [DATA_W*RATIO-1:0] r_data;
    logic [RATIO-1:0]        r_keep;
    logic                    r_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            // Payload is left in place after the drain; only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/handshake_packer.sv
// -----------------------------------------------------------------------------
// handshake_packer
// Packs RATIO consecutive DATA_W-bit beats into one little-endian wide word
// (beat k at bits [k*DATA_W +: DATA_W]) with a per-beat keep mask. in_last
// flushes a partial word early. Sustains one beat per cycle without
// back-pressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake_packer_if.slave (in_* stream in, out_* word out)
// -----------------------------------------------------------------------------
module handshake_packer
    import handshake_packer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RATIO  = DEF_RATIO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    handshake_packer_if.slave      bus
);

    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_W*RATIO-1:0] r_acc;
    logic [RATIO-1:0]        r_keep;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_complete;
    logic [DATA_W*RATIO-1:0] w_word;
    logic [RATIO-1:0]        w_word_keep;
    logic                    w_out_valid;
    logic [DATA_W*RATIO-1:0] w_out_data;
    logic [RATIO-1:0]        w_out_keep;
    logic                    w_out_last;

    // The output slot is free when empty or draining this cycle; this is the
    // only path from out_ready to any output.
    assign w_in_ready = !w_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_complete = w_accept && ((r_cnt == CNT_W'(RATIO - 1)) || bus.in_last);

    // Accumulator merged with the incoming beat; slots above r_cnt stay zero
    // because the accumulator is cleared after every emitted word.
    // NOTE: always_comb assigns defaults first so no path leaves a latch.
    always_comb begin
        w_word                          = r_acc;
        w_word[r_cnt*DATA_W +: DATA_W]  = bus.in_data;
        w_word_keep                     = r_keep;
        w_word_keep[r_cnt]              = 1'b1;
    end

    // NOTE: the accumulator is datapath but is still cleared on reset so an
    // interrupted partial word can never leak into the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_keep <= '0;
        end else if (w_complete) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_keep <= '0;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_acc  <= w_word;
            r_keep <= w_word_keep;
        end
    end

    hs_out_reg #(
        .DATA_W (DATA_W),
        .RATIO  (RATIO)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_complete),
        .i_data  (w_word),
        .i_keep  (w_word_keep),
        .i_last  (bus.in_last),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_keep  (w_out_keep),
        .o_last  (w_out_last)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_keep  = w_out_keep;
    assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_handshake_packer.sv
// -----------------------------------------------------------------------------
// tb_handshake_packer
// Self-checking bench for handshake_packer. A reference model holds the bytes
// of the open packet in a queue and the pending output word as a record; each
// cycle the DUT's in_ready and output word are compared against it.
// -----------------------------------------------------------------------------
module tb_handshake_packer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;

    logic clk;
    logic rst_n;

    handshake_packer_if #(.DATA_W(DATA_W), .RATIO(RATIO)) bus ();

    handshake_packer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0]       m_part[$];
    logic                    m_valid;
    logic [DATA_W*RATIO-1:0] m_data;
    logic [RATIO-1:0]        m_keep;
    logic                    m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_part.delete();
        m_valid = 1'b0;
    endtask

    // Called at a falling edge: drive inputs, compare, advance the model by
    // one rising edge, then return at the next falling edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic l, input logic r);
        logic acc;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        #1;
        check("in_ready", bus.in_ready, !m_valid || r);
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            check("out_data", bus.out_data, m_data);
            check("out_keep", bus.out_keep, m_keep);
            check("out_last", bus.out_last, m_last);
        end
        acc = v && (!m_valid || r);
        if (m_valid && r) m_valid = 1'b0;
        if (acc) begin
            m_part.push_back(d);
            if (m_part.size() == RATIO || l) begin
                m_data = '0;
                foreach (m_part[i]) m_data |= (DATA_W*RATIO)'(m_part[i]) << (DATA_W * i);
                m_keep  = RATIO'((1 << m_part.size()) - 1);
                m_last  = l;
                m_valid = 1'b1;
                m_part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic [3:0] keep, input logic last);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_data"},  bus.out_data,  data);
        check({tag, "_keep"},  bus.out_keep,  keep);
        check({tag, "_last"},  bus.out_last,  last);
    endtask

    initial begin
        logic [DATA_W-1:0] seq[4];
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  32'h0);
        check("rst_out_keep",  bus.out_keep,  4'h0);
        check("rst_out_last",  bus.out_last,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, 1'b1);
        check_word("stream", 32'h44332211, 4'b1111, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(i + 1), 1'b0, 1'b1);
            if (i == 3) check_word("b2b_0", 32'h04030201, 4'b1111, 1'b0);
            if (i == 7) check_word("b2b_1", 32'h08070605, 4'b1111, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Partial flush
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        check_word("flush", 32'h0000BBAA, 4'b0011, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Back-pressure, then drain and reload at the same edge
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC1 + i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        check_word("stall", 32'hC4C3C2C1, 4'b1111, 1'b0);
        cycle(1'b1, 8'hE5, 1'b1, 1'b1);
        check_word("reload", 32'h000000E5, 4'b0001, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Gapped input
        cycle(1'b1, 8'h10, 1'b0, 1'b1);
        cycle(1'b0, 8'hEE, 1'b0, 1'b1);
        cycle(1'b0, 8'hEE, 1'b1, 1'b1);
        cycle(1'b1, 8'h20, 1'b0, 1'b1);
        cycle(1'b1, 8'h30, 1'b0, 1'b1);
        cycle(1'b1, 8'h40, 1'b0, 1'b1);
        check_word("gap", 32'h40302010, 4'b1111, 1'b0);

        // Reset mid-word
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        cycle(1'b1, 8'h66, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", bus.out_valid, 1'b0);
        check("mrst_out_data",  bus.out_data,  32'h0);
        check("mrst_out_keep",  bus.out_keep,  4'h0);
        check("mrst_out_last",  bus.out_last,  1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        seq = '{8'h77, 8'h88, 8'h99, 8'hAA};
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, 1'b1);
        check_word("post_rst", 32'hAA998877, 4'b1111, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
